// File: rtl/nios_system_sysinfo_pkg.sv
// Shared register map, version constant and helpers for the system-information slave.
package nios_system_sysinfo_pkg;

    localparam int REG_ID        = 0;
    localparam int REG_TIMESTAMP = 1;
    localparam int REG_UPTIME_LO = 2;
    localparam int REG_UPTIME_HI = 3;
    localparam int REG_SCRATCH   = 4;
    localparam int REG_CAPS      = 5;
    localparam int REG_CONTROL   = 6;
    localparam int REG_RESERVED  = 7;
    localparam int REG_USER_BASE = 8;

    localparam logic [7:0] VERSION      = 8'd2;
    localparam int         CTRL_CLR_BIT = 0;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) result[8*b +: 8] = new_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/nios_system_sysinfo_uptime.sv
// Free-running 64-bit uptime counter with synchronous clear and a high-word snapshot
// taken whenever the low word is read, so LO-then-HI reads form a coherent pair.
module nios_system_sysinfo_uptime
    import nios_system_sysinfo_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        snap,
    output logic [31:0] count_lo,
    output logic [31:0] snapshot
);

    logic [63:0] count_d,    count_q;
    logic [31:0] snapshot_d, snapshot_q;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_d    = count_q + 64'd1;
        snapshot_d = snapshot_q;
        if (clear) count_d    = '0;
        if (snap)  snapshot_d = count_q[63:32];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            snapshot_q <= '0;
        end else begin
            count_q    <= count_d;
            snapshot_q <= snapshot_d;
        end
    end

    assign count_lo = count_q[31:0];
    assign snapshot = snapshot_q;

endmodule

// File: rtl/nios_system_sysinfo.sv
// Avalon-MM system-information slave: ID, timestamp, uptime, scratch, capabilities
// and live user status words behind a one-cycle registered read path.
module nios_system_sysinfo
    import nios_system_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP  = 32'h5A2D_5BB2,
    parameter int          ADDR_WIDTH = 4,
    parameter int          NUM_USER   = 4,
    localparam int         USER_W     = (NUM_USER > 0) ? 32 * NUM_USER : 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic [31:0]           readdata,
    output logic                  readdatavalid,
    input  logic [USER_W-1:0]     user_status
);

    localparam logic [31:0] CAPS_WORD = {VERSION, 8'(NUM_USER), 8'(ADDR_WIDTH), 8'h00};

    logic [31:0] addr_idx;
    logic        rd_accept;
    logic        uptime_clear;
    logic        uptime_snap;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi_snap;
    logic [31:0] rd_mux;

    logic [31:0] scratch_d,       scratch_q;
    logic [31:0] readdata_d,      readdata_q;
    logic        readdatavalid_d, readdatavalid_q;

    assign addr_idx  = 32'(address);
    // A simultaneous write wins; the read is dropped entirely.
    assign rd_accept    = read & ~write;
    assign uptime_clear = write && (addr_idx == REG_CONTROL) && writedata[CTRL_CLR_BIT];
    assign uptime_snap  = rd_accept && (addr_idx == REG_UPTIME_LO);

    nios_system_sysinfo_uptime u_uptime (
        .clock    (clock),
        .reset    (reset),
        .clear    (uptime_clear),
        .snap     (uptime_snap),
        .count_lo (uptime_lo),
        .snapshot (uptime_hi_snap)
    );

    always_comb begin
        rd_mux = '0;
        case (addr_idx)
            REG_ID:        rd_mux = SYSTEM_ID;
            REG_TIMESTAMP: rd_mux = TIMESTAMP;
            REG_UPTIME_LO: rd_mux = uptime_lo;
            REG_UPTIME_HI: rd_mux = uptime_hi_snap;
            REG_SCRATCH:   rd_mux = scratch_q;
            REG_CAPS:      rd_mux = CAPS_WORD;
            default: begin
                for (int k = 0; k < NUM_USER; k++) begin
                    if (addr_idx == 32'(REG_USER_BASE + k)) rd_mux = user_status[32*k +: 32];
                end
            end
        endcase
    end

    always_comb begin
        scratch_d       = scratch_q;
        readdata_d      = readdata_q;
        readdatavalid_d = rd_accept;
        if (write && (addr_idx == REG_SCRATCH)) scratch_d = merge_bytes(scratch_q, writedata, byteenable);
        if (rd_accept) readdata_d = rd_mux;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_q       <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            scratch_q       <= scratch_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_nios_system_sysinfo.sv
// Scoreboard bench: expected read data queued at issue, compared when readdatavalid arrives.
module tb_nios_system_sysinfo;

    localparam logic [31:0] SYS_ID = 32'h1234_ABCD;
    localparam logic [31:0] TS     = 32'h5A2D_5BB2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   address = '0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  writedata = '0;
    logic [3:0]   byteenable = '0;
    logic [31:0]  readdata;
    logic         readdatavalid;
    logic [127:0] user_status = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    nios_system_sysinfo #(
        .SYSTEM_ID  (SYS_ID),
        .TIMESTAMP  (TS),
        .ADDR_WIDTH (4),
        .NUM_USER   (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .user_status   (user_status)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: valid must follow an accepted read by exactly one edge; data holds otherwise.
    always begin
        logic exp_v;
        @(posedge clock);
        exp_v = read & ~write & ~reset;
        #1;
        check("readdatavalid", 64'(readdatavalid), 64'(exp_v));
        if (reset) begin
            last_exp = '0;
            check("readdata_reset", 64'(readdata), 64'h0);
        end else if (readdatavalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(1), 64'(0));
            end else begin
                last_exp = exp_q.pop_front();
                check("readdata", 64'(readdata), 64'(last_exp));
            end
        end else begin
            check("readdata_hold", 64'(readdata), 64'(last_exp));
        end
    end

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
        @(negedge clock);
        read = 1'b1; write = 1'b0; address = a;
        exp_q.push_back(exp);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        read = 1'b0; write = 1'b1; address = a; writedata = d; byteenable = be;
    endtask

    task automatic do_idle(input int n);
        repeat (n) begin
            @(negedge clock);
            read = 1'b0; write = 1'b0;
        end
    endtask

    initial begin
        do_idle(3);

        // First read after reset release sees the counter at 0.
        @(negedge clock);
        reset = 1'b0; read = 1'b1; address = 4'd2;
        exp_q.push_back(32'd0);
        do_read(4'd3, 32'd0);
        do_read(4'd0, SYS_ID);
        do_read(4'd1, TS);
        do_read(4'd5, 32'h0204_0400);
        do_idle(2);

        do_write(4'd4, 32'hDEAD_BEEF, 4'hF);
        do_write(4'd4, 32'h1122_3344, 4'b0101);
        do_read(4'd4, 32'hDE22_BE44);
        do_idle(1);

        // High-word snapshot is taken at the LO read, just before the carry into bit 32.
        @(negedge clock);
        force dut.u_uptime.count_q = 64'h0000_0001_FFFF_FFFF;
        read = 1'b1; write = 1'b0; address = 4'd2;
        exp_q.push_back(32'hFFFF_FFFF);
        @(negedge clock);
        release dut.u_uptime.count_q;
        read = 1'b0;
        do_idle(3);
        do_read(4'd3, 32'h0000_0001);
        do_idle(1);

        // Clear in cycle N, harmless writes in N+1 and N+2, LO read in N+3 returns 2.
        do_write(4'd6, 32'h0000_0001, 4'hF);
        do_write(4'd0, 32'h0000_0000, 4'hF);
        do_write(4'd6, 32'h0000_0000, 4'hF);
        do_read(4'd2, 32'd2);
        do_read(4'd0, SYS_ID);
        do_write(4'd1, 32'h0000_0000, 4'hF);
        do_read(4'd1, TS);
        do_idle(1);

        user_status = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        do_read(4'd10, 32'hCAFE_0002);
        do_read(4'd8,  32'hCAFE_0000);
        do_read(4'd11, 32'hCAFE_0003);
        do_read(4'd12, 32'd0);
        do_read(4'd7,  32'd0);
        do_read(4'd15, 32'd0);
        do_read(4'd6,  32'd0);
        do_idle(1);

        // Read and write together: write lands, no valid.
        @(negedge clock);
        read = 1'b1; write = 1'b1; address = 4'd4; writedata = 32'h0BAD_F00D; byteenable = 4'hF;
        do_read(4'd4, 32'h0BAD_F00D);
        do_idle(2);

        // Reset arriving with a read suppresses its valid and clears all state.
        @(negedge clock);
        read = 1'b1; write = 1'b0; address = 4'd4; reset = 1'b1;
        @(negedge clock);
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0; read = 1'b1; address = 4'd2;
        exp_q.push_back(32'd0);
        do_read(4'd3, 32'd0);
        do_read(4'd4, 32'd0);
        do_idle(4);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
